// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the shared memory port of the multicycle MIPS system.
// Port 0 is the processor, port 1 the program-loader/DMA engine. One access is in
// flight at a time; strobes are held MEM_LAT cycles, then the owner gets a one-cycle ack.
// MEM_LAT must be >= 1.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1,
    parameter int RR      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_read_data,
    output logic          mem_mr,
    output logic          mem_mw,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          mr_q, mr_d;
    logic          mw_q, mw_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          busy_q, busy_d;
    logic          gnt;

    // Next-state, grant selection and registered-output next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;

        // Round-robin favours the port not granted last; fixed priority favours port 0.
        if (RR != 0) begin
            gnt = (p0_req && p1_req) ? ~last_q : p1_req;
        end else begin
            gnt = ~p0_req;
        end

        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    owner_d = gnt;
                    last_d  = gnt;
                    we_d    = gnt ? p1_we : p0_we;
                    addr_d  = gnt ? p1_addr : p0_addr;
                    wdata_d = gnt ? p1_wdata : p0_wdata;
                    cnt_d   = CNT_LOAD;
                    mr_d    = gnt ? ~p1_we : ~p0_we;
                    mw_d    = gnt ? p1_we : p0_we;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            rd1_d = mem_read_data;
                        end else begin
                            rd0_d = mem_read_data;
                        end
                    end
                    mr_d    = 1'b0;
                    mw_d    = 1'b0;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops strobes immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            busy_q  <= busy_d;
        end
    end

    assign p0_ack    = ack0_q;
    assign p1_ack    = ack1_q;
    assign p0_rdata  = rd0_q;
    assign p1_rdata  = rd1_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_mr    = mr_q;
    assign mem_mw    = mw_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule
